// File: rtl/word_tx_arbiter_if.sv
// Requester slots and word_tx transmit handshake shared by the arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the producers plus word_tx.
interface word_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_word;
  logic [N-1:0]    req_ready;
  logic [31:0]     tx_word;
  logic            tx_send;
  logic            tx_done;

  modport slave (
    input  req_valid, req_word, tx_done,
    output req_ready, tx_word, tx_send
  );

  modport master (
    output req_valid, req_word, tx_done,
    input  req_ready, tx_word, tx_send
  );
endinterface

// File: rtl/word_tx_arbiter.sv
// Round-robin arbiter sharing one word_tx transmitter among N one-word holding slots.
// A granted word owns the transmitter until word_tx reports done.
module word_tx_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  word_tx_arbiter_if.slave   bus,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic [15:0]        sent_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    slot_full_q, slot_full_d;
  logic [31:0]     slot_word_q [N];
  logic [N-1:0]    accept;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [31:0]     tx_word_q, tx_word_d;
  logic            tx_send_q, tx_send_d;
  logic [15:0]     sent_count_q, sent_count_d;
  logic            pick_valid;
  logic [IDW-1:0]  pick_id;

  // Slot index p+k wrapped modulo N (not 2^IDW), k < N.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  assign accept = bus.req_valid & ~slot_full_q;

  // Scan downwards so the full slot closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (slot_full_q[wrap_add(rr_ptr_q, k)]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_full_d  = slot_full_q | accept;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    tx_word_d    = tx_word_q;
    tx_send_d    = 1'b0;
    sent_count_d = sent_count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = SEND;
          grant_d   = pick_id;
          tx_word_d = slot_word_q[pick_id];
          tx_send_d = 1'b1;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        // The granted slot is full here, so it never sees an accept on this edge.
        if (bus.tx_done) begin
          state_d              = IDLE;
          slot_full_d[grant_q] = 1'b0;
          rr_ptr_d             = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
          sent_count_d         = sent_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_full_q  <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      tx_word_q    <= '0;
      tx_send_q    <= 1'b0;
      sent_count_q <= '0;
    end else begin
      state_q      <= state_d;
      slot_full_q  <= slot_full_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      tx_word_q    <= tx_word_d;
      tx_send_q    <= tx_send_d;
      sent_count_q <= sent_count_d;
    end
  end

  // NOTE: slot storage has no reset; slot_full_q qualifies it, so stale contents are never issued.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (accept[i]) slot_word_q[i] <= bus.req_word[32*i +: 32];
    end
  end

  assign bus.req_ready = ~slot_full_q;
  assign bus.tx_word   = tx_word_q;
  assign bus.tx_send   = tx_send_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);
  assign sent_count    = sent_count_q;

endmodule

// File: tb/tb_word_tx_arbiter.sv
// Scoreboard bench for word_tx_arbiter: expected grants are queued at load time and
// compared when tx_send fires; a small word_tx model answers with tx_done.
module tb_word_tx_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic [15:0]     sent_count;

  word_tx_arbiter_if #(.N(N)) bus();

  word_tx_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .sent_count (sent_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    word;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic push(input int id, input logic [31:0] w);
    exp_t e;
    e.id   = IDW'(id);
    e.word = w;
    sb_q.push_back(e);
  endtask

  // Present one word on slot i for a single cycle (called at a negedge, returns at the next).
  task automatic load_slot(input int i, input logic [31:0] w);
    bus.req_valid[i]          = 1'b1;
    bus.req_word[32*i +: 32]  = w;
    @(negedge clk);
    bus.req_valid[i]          = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = '0;
    sb_q.delete();
  endtask

  // Wait for tx_send, compare against the scoreboard, optionally drive a stray tx_done in SEND,
  // then step into WAIT and check the pulse ended without completing anything.
  task automatic serve_issue(input bit stray);
    exp_t e;
    int   waited = 0;
    while (!bus.tx_send && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("send_seen", 32'(bus.tx_send), 32'd1);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("grant_id", 32'(grant_id), 32'(e.id));
      check("tx_word", bus.tx_word, e.word);
    end
    if (stray) bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("send_pulse", 32'(bus.tx_send), 32'd0);
    check("busy_wait", 32'(busy), 32'd1);
    check("count_hold", 32'(sent_count), 32'(exp_count));
  endtask

  // word_tx model: after gap extra WAIT cycles, pulse tx_done for one clock.
  task automatic serve_done(input int gap);
    repeat (gap) @(negedge clk);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    exp_count   = exp_count + 16'd1;
    check("busy_idle", 32'(busy), 32'd0);
    check("sent_count", 32'(sent_count), 32'(exp_count));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_word  = '0;
    bus.tx_done   = 1'b0;
    #12;
    check("rst_ready", 32'(bus.req_ready), 32'hF);
    check("rst_tx_word", bus.tx_word, 32'd0);
    check("rst_tx_send", 32'(bus.tx_send), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(sent_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word with accept-to-send latency.
    load_slot(0, 32'hDEADBEEF);
    push(0, 32'hDEADBEEF);
    check("ready_full", 32'(bus.req_ready[0]), 32'd0);
    check("lat_early", 32'(bus.tx_send), 32'd0);
    @(negedge clk);
    check("lat_send", 32'(bus.tx_send), 32'd1);
    serve_issue(1'b0);
    serve_done(2);
    check("ready_free", 32'(bus.req_ready[0]), 32'd1);

    // Round-robin from a fresh pointer, reloading slot 0 during the slot-1 transfer.
    do_reset();
    bus.req_valid = 4'hF;
    bus.req_word  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    @(negedge clk);
    bus.req_valid = '0;
    for (int i = 0; i < N; i++) push(i, {4'(i + 1), 4'(i + 1), 4'(i + 1), 4'(i + 1),
                                         4'(i + 1), 4'(i + 1), 4'(i + 1), 4'(i + 1)});
    serve_issue(1'b0);
    serve_done(0);
    serve_issue(1'b0);
    load_slot(0, 32'hAAAA5555);
    push(0, 32'hAAAA5555);
    serve_done(1);
    for (int i = 0; i < 3; i++) begin
      serve_issue(1'b0);
      serve_done(i);
    end

    // Pointer fairness: after slot 2, slot 3 goes before slot 1.
    load_slot(2, 32'h22220002);
    push(2, 32'h22220002);
    serve_issue(1'b0);
    bus.req_valid            = 4'b1010;
    bus.req_word[32*1 +: 32] = 32'h11110001;
    bus.req_word[32*3 +: 32] = 32'h33330003;
    @(negedge clk);
    bus.req_valid = '0;
    push(3, 32'h33330003);
    push(1, 32'h11110001);
    serve_done(0);
    for (int i = 0; i < 2; i++) begin
      serve_issue(1'b0);
      serve_done(1);
    end

    // Backpressure on a full slot; the held word is taken one cycle after the done edge.
    load_slot(1, 32'hA0A0A0A0);
    push(1, 32'hA0A0A0A0);
    serve_issue(1'b0);
    bus.req_valid[1]         = 1'b1;
    bus.req_word[32*1 +: 32] = 32'hB1B1B1B1;
    @(negedge clk);
    check("bp_ready_low", 32'(bus.req_ready[1]), 32'd0);
    check("bp_word_hold", bus.tx_word, 32'hA0A0A0A0);
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    exp_count   = exp_count + 16'd1;
    check("bp_count", 32'(sent_count), 32'(exp_count));
    check("bp_ready_rise", 32'(bus.req_ready[1]), 32'd1);
    @(negedge clk);
    check("bp_accept", 32'(bus.req_ready[1]), 32'd0);
    bus.req_valid[1] = 1'b0;
    push(1, 32'hB1B1B1B1);
    serve_issue(1'b0);
    serve_done(0);

    // Stray tx_done in IDLE, then in SEND.
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_count", 32'(sent_count), 32'(exp_count));
    load_slot(3, 32'h5A5A3333);
    push(3, 32'h5A5A3333);
    serve_issue(1'b1);
    serve_done(1);

    // Asynchronous reset in WAIT with slots 1..3 full.
    bus.req_valid            = 4'b1110;
    bus.req_word[32*1 +: 32] = 32'hC1C1C1C1;
    bus.req_word[32*2 +: 32] = 32'hC2C2C2C2;
    bus.req_word[32*3 +: 32] = 32'hC3C3C3C3;
    @(negedge clk);
    bus.req_valid = '0;
    push(1, 32'hC1C1C1C1);
    serve_issue(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.req_ready), 32'hF);
    check("arst_tx_word", bus.tx_word, 32'd0);
    check("arst_tx_send", 32'(bus.tx_send), 32'd0);
    check("arst_grant", 32'(grant_id), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(sent_count), 32'd0);
    exp_count = '0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    load_slot(2, 32'hD2D2D2D2);
    push(2, 32'hD2D2D2D2);
    serve_issue(1'b0);
    serve_done(0);

    // sent_count wrap from 0xFFFF.
    force dut.sent_count_q = 16'hFFFF;
    #1 release dut.sent_count_q;
    exp_count = 16'hFFFF;
    @(negedge clk);
    check("preload", 32'(sent_count), 32'h0000FFFF);
    load_slot(1, 32'hE1E1E1E1);
    push(1, 32'hE1E1E1E1);
    serve_issue(1'b0);
    serve_done(0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/word_tx_arbiter.md
# word_tx_arbiter

Round-robin arbiter that shares the single `word_tx` → `uart_tx` transmit path between `N` independent 32-bit word sources (trace, debug and status producers). Each requester owns a one-word holding slot with a valid/ready handshake. The arbiter selects the next full slot, issues the word to `word_tx`, and waits for its `done` pulse before selecting again. It sits between the core-side producers and `word_tx`.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(N)`: width of the grant index.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N: requester i presents a word on bit i.
- `req_word` in 32*N: word for requester i on bits `[32*i+31:32*i]`.
- `req_ready` out N: slot i is empty; the word is accepted when `req_valid[i] && req_ready[i]` at a posedge.
- `tx_word` out 32: word to `word_tx.in`.
- `tx_send` out 1: one-cycle pulse to `word_tx.send_in`.
- `tx_done` in 1: from `word_tx.done`; high for one clock.
- `grant_id` out IDW: index of the word currently owned by the transmitter.
- `busy` out 1: high when state ≠ IDLE.
- `sent_count` out 16: count of words completed, wraps.

## Operation
- Per-slot state: `slot_full[i]` and `slot_word[i]`. `req_ready[i] = !slot_full[i]`, combinational from state only and never from `req_valid`.
- Accept: on a posedge with `req_valid[i] && !slot_full[i]`, set `slot_full[i]` and store the word.
- FSM states: IDLE, SEND, WAIT.
  - IDLE → SEND when any `slot_full`. At that edge:
    - `grant_id` is set to the first full slot scanning from `rr_ptr` upward, modulo N.
    - `tx_word` is set to that slot's word.
    - `tx_send` is set to 1.
  - SEND → WAIT unconditionally after one cycle; `tx_send` is set to 0.
  - WAIT → IDLE when `tx_done` is sampled high. At that edge:
    - `slot_full[grant_id]` is cleared.
    - `rr_ptr` is set to `(grant_id+1) mod N`.
    - `sent_count` increments.
- `rr_ptr` resets to 0. Its wrap uses modulo N, not 2^IDW, for non-power-of-2 N.
- `tx_done` outside WAIT, including in SEND, is ignored.
- `tx_word` and `grant_id` hold stable from the SEND entry until the next SEND entry.
- Slot i is cleared at a done edge; `req_ready[i]` rises the cycle after, so a new word for slot i is accepted one cycle after clear at the earliest. A concurrent accept and clear on the same slot cannot occur.
- Accepts into other slots proceed in any state, including during SEND and WAIT.
- `sent_count` wraps 0xFFFF → 0x0000.

## Timing
- Reset values:
  - `req_ready` = all ones.
  - `tx_word` = 0.
  - `tx_send` = 0.
  - `grant_id` = 0.
  - `busy` = 0.
  - `sent_count` = 0.
  - All slots empty; `rr_ptr` = 0; state = IDLE.
- Reset mid-operation: all slots are dropped; `tx_send` deasserts immediately, asynchronously. `rst_n` must be applied to the whole transmit path together; a `word_tx` transfer in flight is not tracked.
- Latency from accept edge k to `tx_send` high: `tx_send` is high during cycle k+1→k+2 when the arbiter is idle.
- `tx_send` is driven from a posedge register and is stable over the negedge on which `word_tx` samples it.
- Minimum spacing between issued words: SEND (1 cycle), then WAIT until `tx_done`, then 1 IDLE cycle.
- Throughput is bounded by the UART: 4 bytes per word.

## Test plan
- Single word: slot 0 gets `0xDEADBEEF` → `tx_send` for one cycle, `tx_word` = `0xDEADBEEF`, `grant_id` = 0. After a model `tx_done`: `busy` = 0, `sent_count` = 1, `req_ready[0]` = 1.
- Round-robin, all four slots loaded simultaneously with `0x11111111`..`0x44444444` → issue order is 0,1,2,3. Reload slot 0 during the slot-1 transfer → slot 0 is issued only after slot 3.
- Pointer fairness: after slot 2 completes, slots 1 and 3 both full → slot 3 is issued first, then slot 1.
- Backpressure: hold `req_valid[1]` while slot 1 is full → `req_ready[1]` = 0 and the word stays unchanged. The second word is accepted one cycle after the done edge.
- Stray `tx_done` in IDLE and in SEND → no state change and no count increment.
- Async reset asserted in WAIT with 3 slots full → all outputs go to their reset values at once. After release, a new slot-2 word issues with `grant_id` = 2. Separately, preload `sent_count` to 0xFFFF and complete one word → `sent_count` = 0x0000.
